// File: rtl/bvslt_bvand_skolem_checker_if.sv
// Bit-serial operand stream and result/tally bundle for the bvslt/bvand Skolem checker.
// The master is the harness that feeds operands; the slave is the checker.
interface bvslt_bvand_skolem_checker_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             witness;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             c_bit;
  logic             bit_ready;
  logic             busy;
  logic             done;
  logic             result;
  logic             match;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output start, witness, bit_valid, a_bit, b_bit, c_bit,
    input  bit_ready, busy, done, result, match, pass_cnt, fail_cnt
  );

  modport slave (
    input  start, witness, bit_valid, a_bit, b_bit, c_bit,
    output bit_ready, busy, done, result, match, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/bvslt_bvand_skolem_checker.sv
// Serial evaluator of r = (a & b) <s c, MSB first, checked against a latched Skolem
// witness bit with saturating pass/fail tallies.
module bvslt_bvand_skolem_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  bvslt_bvand_skolem_checker_if.slave    bus
);

  localparam int IW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIGN,
    S_MAG,
    S_REPORT
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             lt;
  logic             wit;
  logic             bit_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             result_q;
  logic             match_q;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;

  logic             xfer;
  logic             x;
  logic             sign_decide;
  logic             sign_lt;
  logic             mag_decide;
  logic             lt_final;

  assign xfer = bus.bit_valid & bit_ready_q;

  // In the sign position the order flips: a set MSB means negative, so x=1,c=0 is x<c.
  // In magnitude positions the first differing bit decides with the usual order.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    x           = 1'b0;
    sign_decide = 1'b0;
    sign_lt     = 1'b0;
    mag_decide  = 1'b0;
    lt_final    = lt;
    x           = bus.a_bit & bus.b_bit;
    sign_decide = x ^ bus.c_bit;
    sign_lt     = x & ~bus.c_bit;
    mag_decide  = ~decided & (x ^ bus.c_bit);
    if (mag_decide) begin
      lt_final = ~x & bus.c_bit;
    end
  end

  // NOTE: all state here is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      decided     <= 1'b0;
      lt          <= 1'b0;
      wit         <= 1'b0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 1'b0;
      match_q     <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            wit         <= bus.witness;
            decided     <= 1'b0;
            lt          <= 1'b0;
            idx         <= IW'(W - 1);
            bit_ready_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= S_SIGN;
          end
        end

        S_SIGN: begin
          if (xfer) begin
            decided <= sign_decide;
            lt      <= sign_lt;
            idx     <= idx - 1'b1;
            state   <= S_MAG;
          end
        end

        S_MAG: begin
          if (xfer) begin
            if (mag_decide) begin
              decided <= 1'b1;
              lt      <= lt_final;
            end
            if (idx == '0) begin
              // Last bit: publish the verdict so done, result, match and the
              // tallies all become visible together in the REPORT cycle.
              bit_ready_q <= 1'b0;
              done_q      <= 1'b1;
              result_q    <= lt_final;
              match_q     <= (lt_final == wit);
              if (lt_final == wit) begin
                if (pass_q != '1) pass_q <= pass_q + 1'b1;
              end else begin
                if (fail_q != '1) fail_q <= fail_q + 1'b1;
              end
              state <= S_REPORT;
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end

        S_REPORT: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          bit_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bit_ready = bit_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.match     = match_q;
  assign bus.pass_cnt  = pass_q;
  assign bus.fail_cnt  = fail_q;

endmodule

// File: tb/tb_bvslt_bvand_skolem_checker.sv
// Directed bench for bvslt_bvand_skolem_checker: a 16-bit-counter and a 2-bit-counter
// instance share one stimulus and are compared every cycle against a signed-arithmetic model.
module tb_bvslt_bvand_skolem_checker;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  logic start, witness, bit_valid, a_bit, b_bit, c_bit;

  bvslt_bvand_skolem_checker_if #(.CNT_W(16)) bus16 ();
  bvslt_bvand_skolem_checker_if #(.CNT_W(2))  bus2  ();

  assign bus16.start     = start;
  assign bus16.witness   = witness;
  assign bus16.bit_valid = bit_valid;
  assign bus16.a_bit     = a_bit;
  assign bus16.b_bit     = b_bit;
  assign bus16.c_bit     = c_bit;
  assign bus2.start      = start;
  assign bus2.witness    = witness;
  assign bus2.bit_valid  = bit_valid;
  assign bus2.a_bit      = a_bit;
  assign bus2.b_bit      = b_bit;
  assign bus2.c_bit      = c_bit;

  bvslt_bvand_skolem_checker #(.W(W), .CNT_W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  bvslt_bvand_skolem_checker #(.W(W), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: verdict of the last completed check and raw tallies.
  int   done_cyc = -1;
  logic m_result = 1'b0;
  logic m_match  = 1'b0;
  int   m_pass   = 0;
  int   m_fail   = 0;
  bit   cmp_en   = 1'b0;

  function automatic logic model_lt(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] c);
    logic signed [W-1:0] x;
    logic signed [W-1:0] cs;
    x  = a & b;
    cs = c;
    return (x < cs);
  endfunction

  function automatic logic [31:0] sat(input int v, input int bits);
    int lim;
    lim = (1 << bits) - 1;
    return (v > lim) ? 32'(lim) : 32'(v);
  endfunction

  task automatic model_reset();
    done_cyc = -1;
    m_result = 1'b0;
    m_match  = 1'b0;
    m_pass   = 0;
    m_fail   = 0;
  endtask

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("done16",   32'(bus16.done),   32'(cyc == done_cyc));
      check("done2",    32'(bus2.done),    32'(cyc == done_cyc));
      check("result16", 32'(bus16.result), 32'(m_result));
      check("result2",  32'(bus2.result),  32'(m_result));
      check("match16",  32'(bus16.match),  32'(m_match));
      check("match2",   32'(bus2.match),   32'(m_match));
      check("pass16",   32'(bus16.pass_cnt), sat(m_pass, 16));
      check("pass2",    32'(bus2.pass_cnt),  sat(m_pass, 2));
      check("fail16",   32'(bus16.fail_cnt), sat(m_fail, 16));
      check("fail2",    32'(bus2.fail_cnt),  sat(m_fail, 2));
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},   32'(bus16.done | bus2.done), 0);
    check({tag, "_busy"},   32'(bus16.busy | bus2.busy), 0);
    check({tag, "_ready"},  32'(bus16.bit_ready | bus2.bit_ready), 0);
    check({tag, "_result"}, 32'(bus16.result | bus2.result), 0);
    check({tag, "_match"},  32'(bus16.match | bus2.match), 0);
    check({tag, "_pass16"}, 32'(bus16.pass_cnt), 0);
    check({tag, "_fail16"}, 32'(bus16.fail_cnt), 0);
    check({tag, "_pass2"},  32'(bus2.pass_cnt), 0);
    check({tag, "_fail2"},  32'(bus2.fail_cnt), 0);
  endtask

  // One check: inputs change 1 time unit after a rising edge. stall_before names the
  // bit index preceded by nstall idle cycles (start pulsed during one of them);
  // abort_after resets the DUTs after that many transfers.
  task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic wit,
                           input int stall_before, input int nstall, input int abort_after);
    logic lt;
    int   n;
    start   = 1'b1;
    witness = wit;
    @(posedge clk); #1;
    start   = 1'b0;
    witness = ~wit;
    check("busy_after_start",  32'(bus16.busy), 1);
    check("ready_after_start", 32'(bus16.bit_ready), 1);
    n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i == stall_before) begin
        for (int s = 0; s < nstall; s++) begin
          bit_valid = 1'b0;
          a_bit = ~a[i]; b_bit = ~b[i]; c_bit = ~c[i];
          start = (s == 1);
          @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_in_stall", 32'(bus16.busy), 1);
      end
      bit_valid = 1'b1;
      a_bit = a[i]; b_bit = b[i]; c_bit = c[i];
      @(posedge clk); #1;
      n++;
      if (n == abort_after) begin
        bit_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    bit_valid = 1'b0;
    lt        = model_lt(a, b, c);
    done_cyc  = cyc;
    m_result  = lt;
    m_match   = (lt == wit);
    if (lt == wit) m_pass++; else m_fail++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; witness = 1'b0; bit_valid = 1'b0;
    a_bit = 1'b0; b_bit = 1'b0; c_bit = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // bit_valid with no start must not begin a check.
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1; c_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1 bit_valid = 1'b0;
    check("idle_ignores_bits", 32'(bus16.busy | bus16.bit_ready), 0);

    // -6 < 3, decided at the sign bit.
    run_check(4'b1111, 4'b1010, 4'b0011, 1'b1, -1, 0, -1);
    check("t1_result", 32'(bus16.result), 1);
    check("t1_match",  32'(bus16.match), 1);
    check("t1_pass",   32'(bus16.pass_cnt), 1);

    // 5 vs 5, never decided.
    run_check(4'b0111, 4'b0101, 4'b0101, 1'b1, -1, 0, -1);
    check("t2_result", 32'(bus16.result), 0);
    check("t2_match",  32'(bus16.match), 0);
    check("t2_fail",   32'(bus16.fail_cnt), 1);

    // 3 vs -8, decided at the sign bit, later bits irrelevant.
    run_check(4'b0011, 4'b1111, 4'b1000, 1'b0, -1, 0, -1);
    check("t3_result", 32'(bus16.result), 0);
    check("t3_match",  32'(bus16.match), 1);

    // 4 < 5 decided only at bit 0, with a 3-cycle stall before bit 1.
    run_check(4'b1100, 4'b0110, 4'b0101, 1'b1, 1, 3, -1);
    check("t4_result", 32'(bus16.result), 1);
    check("t4_pass",   32'(bus16.pass_cnt), 3);

    // Abort after 2 transfers, then a fresh check: -8 < 7.
    run_check(4'b1111, 4'b1010, 4'b0011, 1'b1, -1, 0, 2);
    run_check(4'b1000, 4'b1000, 4'b0111, 1'b1, -1, 0, -1);
    check("fresh_result", 32'(bus16.result), 1);
    check("fresh_pass",   32'(bus16.pass_cnt), 1);

    // Four more matches saturate the 2-bit counter, then one mismatch.
    run_check(4'b1111, 4'b1010, 4'b0011, 1'b1, -1, 0, -1);
    run_check(4'b0011, 4'b1111, 4'b1000, 1'b0, -1, 0, -1);
    run_check(4'b1100, 4'b0110, 4'b0101, 1'b1, -1, 0, -1);
    run_check(4'b0110, 4'b0110, 4'b0110, 1'b0, -1, 0, -1);
    run_check(4'b0111, 4'b0101, 4'b0101, 1'b1, -1, 0, -1);
    check("sat_pass2",  32'(bus2.pass_cnt), 3);
    check("sat_pass16", 32'(bus16.pass_cnt), 5);
    check("sat_fail2",  32'(bus2.fail_cnt), 1);
    check("sat_fail16", 32'(bus16.fail_cnt), 1);

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bvslt_bvand_skolem_checker.md
Name: bvslt_bvand_skolem_checker

Overview:
- Sequential checker for the bvslt/bvand Skolem witness bit (single witness per check).
- Receives operand bit-vectors a, b, c bit-serially, MSB first, and evaluates r = ((a & b) <s c) with signed two's-complement comparison.
- Compares r against the supplied Skolem witness and keeps pass/fail tallies.
- Sits downstream of the combinational Skolem-function blocks in the validation harness. It is the evaluation side that checks what the generator produced.

Parameters:
- W, 4, operand width in bits (>= 2).
- CNT_W, 16, width of pass/fail counters (saturating).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a check; sampled only in IDLE.
- witness  in  1  Skolem output bit under test; latched when start is accepted.
- bit_valid  in  1  a_bit/b_bit/c_bit hold the current operand bit.
- a_bit  in  1  operand a bit, MSB first.
- b_bit  in  1  operand b bit, MSB first.
- c_bit  in  1  operand c bit, MSB first.
- bit_ready  out  1  high in SIGN and MAG; a bit transfers when bit_valid & bit_ready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  1  evaluated (a&b) <s c; held until the next done.
- match  out  1  result == latched witness; held until the next done.
- pass_cnt  out  CNT_W  number of checks with match=1, saturating.
- fail_cnt  out  CNT_W  number of checks with match=0, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; bit_ready, busy, done, result, match = 0; pass_cnt = fail_cnt = 0.
  - Bit counter and witness latch cleared.
- States: IDLE, SIGN, MAG, REPORT.
- IDLE:
  - start=1 → latch witness, clear the decided flag, set bit index to W-1, go to SIGN.
  - bit_valid is ignored in IDLE.
- SIGN (first transfer, MSB). Let x = a_bit & b_bit:
  - x=1, c=0 → decided, lt=1.
  - x=0, c=1 → decided, lt=0.
  - Otherwise undecided.
  - Decrement index, go to MAG.
- MAG (remaining W-1 transfers):
  - If undecided and x != c_bit → decided, lt = (~x & c_bit).
  - Once decided, later bits are consumed but cannot change lt.
  - The transfer at index 0 goes to REPORT.
  - If never decided, lt=0 (equal operands).
- REPORT (one cycle):
  - done=1; result=lt; match=(lt==witness).
  - Increment pass_cnt if match, else fail_cnt; counters saturate at all-ones.
  - Go to IDLE.
- Latency: done is asserted exactly one cycle after the W-th accepted transfer.
- A check with no stalls takes W+2 cycles from start to done inclusive.
- bit_valid=0 in SIGN/MAG stalls the check with no state change; stalls have no timeout.
- start while busy is ignored; it does not restart or queue.
- start is accepted in the cycle after REPORT (back-to-back checks allowed). done is not asserted while in IDLE.
- Reset asserted mid-check aborts it: no done, counters cleared.
- result and match keep their last values between checks. They are 0 after reset until the first done.

Test Plan:
- W=4: a=1111, b=1010, c=0011, witness=1 → x=-6 < 3; done 6 cycles after start with result=1, match=1, pass_cnt=1.
- a=0111, b=0101, c=0101, witness=1 → equal, result=0, match=0, fail_cnt=1; the sign/magnitude path reaches index 0 undecided.
- a=0011, b=1111, c=1000, witness=0 → 3 vs -8, result=0, match=1; decided at SIGN, later bits ignored.
- Insert 3 bit_valid=0 stall cycles between bit 2 and bit 1, and pulse start during the stall → start is ignored and done arrives 3 cycles late with the correct result.
- Assert rst_n=0 after 2 transfers → outputs and counters read 0 immediately (async); after release a fresh check completes normally.
- Force pass_cnt to saturation (CNT_W=2, 4 matching checks) → pass_cnt stays 3; fail_cnt unaffected.
